// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_pkg
//  Purpose  : Shared definitions for the PS/2 host-side blocks: FSM state
//             encoding, frame bit indices, default timing and a small helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package ps2_pkg;

  // Default timing at a 50 MHz system clock.
  localparam int DEF_INHIBIT_CYCLES = 5000;    // 100 us clock inhibit
  localparam int DEF_TIMEOUT_CYCLES = 750000;  // 15 ms between device edges

  // Transmit FSM state encoding.
  typedef logic [2:0] ps2_state_t;
  localparam ps2_state_t ST_IDLE      = 3'd0;
  localparam ps2_state_t ST_INHIBIT   = 3'd1;
  localparam ps2_state_t ST_RELEASE   = 3'd2;
  localparam ps2_state_t ST_SHIFT     = 3'd3;
  localparam ps2_state_t ST_WAIT_IDLE = 3'd4;
  localparam ps2_state_t ST_FINISH    = 3'd5;

  // Frame bit indices as counted by device clock falls.
  localparam logic [3:0] BIT_START     = 4'd0;
  localparam logic [3:0] BIT_DATA_LAST = 4'd8;
  localparam logic [3:0] BIT_PARITY    = 4'd9;
  localparam logic [3:0] BIT_STOP      = 4'd10;
  localparam logic [3:0] BIT_ACK       = 4'd11;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_sync_edge
//  Purpose  : Two-flop synchronizer for an asynchronous PS/2 line plus a
//             one-cycle strobe on each falling edge of the synchronized level.
//  Ports    : in_clk    - system clock
//             in_reset  - asynchronous active-high reset (line reads idle high)
//             in_line   - raw asynchronous line level
//             out_level - synchronized line level
//             out_fall  - one-cycle pulse on a synchronized 1->0 transition
//  Revision : 1.0  initial release
// ============================================================================
module ps2_sync_edge (
  input  logic in_clk,
  input  logic in_reset,
  input  logic in_line,
  output logic out_level,
  output logic out_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Reset to 1 so that leaving reset never fabricates a falling edge.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= in_line;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign out_level = r_sync;
  assign out_fall  = r_prev & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/ps2_transmit.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_transmit
//  Purpose  : PS/2 host-to-device byte transmitter. Inhibits the clock, issues
//             the start bit, shifts data/parity/stop on device clock falls,
//             checks the device ack and reports done or error.
//  Ports    : in_clk      - system clock (rising edge)
//             in_reset    - asynchronous active-high reset
//             in_valid    - send request, sampled only while idle
//             in_data     - command byte to send
//             ps2_clk_in  - raw PS/2 clock line level
//             ps2_data_in - raw PS/2 data line level
//             ps2_clk_oe  - 1 pulls the clock line low
//             ps2_data_oe - 1 pulls the data line low
//             out_busy    - high while not idle
//             out_done    - one-cycle pulse on acknowledged transfer
//             out_error   - one-cycle pulse on missing ack or timeout
//  Revision : 1.0  initial release
// ============================================================================
module ps2_transmit
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       in_clk,
  input  logic       in_reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       out_busy,
  output logic       out_done,
  output logic       out_error
);

  localparam int CW = $clog2(max_int(INHIBIT_CYCLES, TIMEOUT_CYCLES) + 1);

  localparam logic [CW-1:0] C_INHIBIT   = CW'(INHIBIT_CYCLES);
  localparam logic [CW-1:0] C_INH_LAST  = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] C_TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] C_CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] C_CNT_MAX   = {CW{1'b1}};

  ps2_state_t    r_state;
  logic [CW-1:0] r_cnt;        // inhibit cycle counter
  logic [CW-1:0] r_tmo;        // cycles since last device clock fall
  logic [3:0]    r_bit;        // device clock falls seen in this frame
  logic [8:0]    r_shift;      // {parity, data}, shifted out LSB first
  logic          r_done_flag;
  logic          r_err_flag;
  logic          r_data_meta;
  logic          r_data_sync;
  logic          r_clk_oe;
  logic          r_data_oe;

  logic          w_clk_sync;
  logic          w_clk_fall;
  logic [3:0]    w_bit_next;
  logic          w_tmo_expired;
  logic [CW-1:0] w_tmo_inc;
  logic [CW-1:0] w_cnt_inc;

  ps2_sync_edge u_clk_sync (
    .in_clk    (in_clk),
    .in_reset  (in_reset),
    .in_line   (ps2_clk_in),
    .out_level (w_clk_sync),
    .out_fall  (w_clk_fall)
  );

  // The data line needs only a level, so no edge detector here.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      r_data_meta <= 1'b1;
      r_data_sync <= 1'b1;
    end else begin
      r_data_meta <= ps2_data_in;
      r_data_sync <= r_data_meta;
    end
  end

  assign w_bit_next    = r_bit + 4'd1;
  // Expiry is flagged one cycle early so FINISH lands exactly TIMEOUT_CYCLES
  // after the counter was last reloaded.
  assign w_tmo_expired = (r_tmo >= C_TMO_LAST);
  assign w_tmo_inc     = (r_tmo == C_CNT_MAX) ? r_tmo : r_tmo + C_CNT_ONE;
  assign w_cnt_inc     = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + C_CNT_ONE;

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_tmo       <= '0;
      r_bit       <= 4'd0;
      r_shift     <= 9'd0;
      r_done_flag <= 1'b0;
      r_err_flag  <= 1'b0;
      r_clk_oe    <= 1'b0;
      r_data_oe   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done_flag <= 1'b0;
          r_err_flag  <= 1'b0;
          r_clk_oe    <= 1'b0;
          r_data_oe   <= 1'b0;
          r_bit       <= 4'd0;
          if (in_valid) begin
            r_shift   <= {~^in_data, in_data};
            r_cnt     <= C_CNT_ONE;
            r_clk_oe  <= 1'b1;
            // A one-cycle inhibit carries the start bit on its only cycle.
            r_data_oe <= (INHIBIT_CYCLES <= 1);
            r_state   <= ST_INHIBIT;
          end
        end

        ST_INHIBIT: begin
          if (r_cnt >= C_INHIBIT) begin
            r_clk_oe <= 1'b0;
            r_tmo    <= '0;
            r_state  <= ST_RELEASE;
          end else begin
            r_cnt <= w_cnt_inc;
            // Start bit appears on the last inhibited cycle.
            if (r_cnt == C_INH_LAST) begin
              r_data_oe <= 1'b1;
            end
          end
        end

        ST_RELEASE, ST_SHIFT: begin
          if (w_clk_fall) begin
            r_tmo   <= '0;
            r_bit   <= w_bit_next;
            r_state <= ST_SHIFT;
            if (w_bit_next <= BIT_PARITY) begin
              // Data bits then parity; the shift register holds both.
              r_data_oe <= ~r_shift[0];
              r_shift   <= r_shift >> 1;
            end else if (w_bit_next == BIT_STOP) begin
              r_data_oe <= 1'b0;
            end else begin
              // Ack slot: the device must be pulling data low.
              if (!r_data_sync) begin
                r_state <= ST_WAIT_IDLE;
              end else begin
                r_err_flag <= 1'b1;
                r_state    <= ST_FINISH;
              end
            end
          end else if (w_tmo_expired) begin
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_err_flag <= 1'b1;
            r_state    <= ST_FINISH;
          end else begin
            r_tmo <= w_tmo_inc;
          end
        end

        ST_WAIT_IDLE: begin
          if (w_clk_sync && r_data_sync) begin
            r_done_flag <= 1'b1;
            r_state     <= ST_FINISH;
          end else if (w_clk_fall) begin
            r_tmo <= '0;
          end else if (w_tmo_expired) begin
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_err_flag <= 1'b1;
            r_state    <= ST_FINISH;
          end else begin
            r_tmo <= w_tmo_inc;
          end
        end

        ST_FINISH: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign out_busy    = (r_state != ST_IDLE);
  assign out_done    = (r_state == ST_FINISH) & r_done_flag;
  assign out_error   = (r_state == ST_FINISH) & r_err_flag;

endmodule
`default_nettype wire

// File: tb/tb_ps2_transmit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_transmit
//  Purpose  : Self-checking bench for ps2_transmit with an open-drain PS/2
//             device model clocking every 40 cycles.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ps2_transmit;

  localparam int INH = 10;
  localparam int TMO = 200;

  logic       in_clk   = 1'b0;
  logic       in_reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data  = 8'h00;
  logic       dev_clk  = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_oe, ps2_data_oe, out_busy, out_done, out_error;
  logic       ps2_clk_line, ps2_data_line;

  // Open-drain wired-AND of host and device.
  assign ps2_clk_line  = ~ps2_clk_oe  & dev_clk;
  assign ps2_data_line = ~ps2_data_oe & dev_data;

  ps2_transmit #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .in_clk      (in_clk),
    .in_reset    (in_reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .ps2_clk_in  (ps2_clk_line),
    .ps2_data_in (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .out_busy    (out_busy),
    .out_done    (out_done),
    .out_error   (out_error)
  );

  always #5 in_clk = ~in_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Event monitors sampled on the falling edge.
  int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, busy_bad = 0;
  int run_len = 0, inh_len_last = 0, inh_data_cnt = 0, inh_starts = 0;
  int rel_cyc = 0, err_cyc = 0;
  bit prev_done = 1'b0, prev_clk_oe = 1'b0;

  always @(negedge in_clk) begin
    cyc = cyc + 1;
    if (out_done)              done_cnt = done_cnt + 1;
    if (out_error) begin       err_cnt = err_cnt + 1; err_cyc = cyc; end
    if (out_done && out_error) both_cnt = both_cnt + 1;
    if (prev_done && out_busy) busy_bad = busy_bad + 1;
    if (ps2_clk_oe) begin
      if (!prev_clk_oe) inh_starts = inh_starts + 1;
      run_len = run_len + 1;
      if (ps2_data_oe) inh_data_cnt = inh_data_cnt + 1;
    end else if (prev_clk_oe) begin
      inh_len_last = run_len;
      run_len      = 0;
      rel_cyc      = cyc;
    end
    prev_done   = out_done;
    prev_clk_oe = ps2_clk_oe;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic request(input logic [7:0] d);
    @(negedge in_clk);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge in_clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_release(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ps2_clk_oe; i++) @(negedge in_clk);
    if (!ps2_clk_oe) return;
    for (int i = 0; i < 100 && ps2_clk_oe; i++) @(negedge in_clk);
    ok = !ps2_clk_oe;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && out_busy; i++) @(negedge in_clk);
    ok = !out_busy;
  endtask

  // Device model: 11 clock pulses, 20 cycles high then 20 low; samples the
  // data line just before each rising edge; drives ack after the stop bit.
  task automatic serve(input bit ack, input int abort_fall,
                       output logic [9:0] bits, output logic start_bit);
    bit ok;
    bits      = 10'h000;
    start_bit = 1'b1;
    wait_release(ok);
    check("release_seen", 32'(ok), 32'd1);
    if (!ok) return;
    start_bit = ps2_data_line;
    for (int n = 1; n <= 11; n++) begin
      repeat (20) @(negedge in_clk);
      dev_clk = 1'b0;
      if (n == abort_fall) begin
        repeat (2) @(negedge in_clk);
        in_reset = 1'b1;
        #1;
        check("rst_clk_oe",  32'(ps2_clk_oe),  32'd0);
        check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        check("rst_busy",    32'(out_busy),    32'd0);
        check("rst_pulses",  32'(out_done | out_error), 32'd0);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (5) @(negedge in_clk);
        in_reset = 1'b0;
        return;
      end
      repeat (20) @(negedge in_clk);
      if (n <= 10) bits[n-1] = ps2_data_line;
      if (n == 10 && ack) dev_data = 1'b0;
      dev_clk = 1'b1;
      if (n == 11) begin
        repeat (2) @(negedge in_clk);
        dev_data = 1'b1;
      end
    end
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack;
    logic [9:0] exp_bits;   // transmitted order: data[0..7], parity, stop
    int         exp_done;
    int         exp_err;
  } vec_t;

  vec_t vecs[4];

  task automatic run_vector(input vec_t v);
    int d0, e0, k0;
    bit ok;
    logic [9:0] bits;
    logic start_bit;
    d0 = done_cnt; e0 = err_cnt; k0 = inh_data_cnt;
    request(v.data);
    serve(v.ack, 0, bits, start_bit);
    wait_idle(ok);
    repeat (3) @(negedge in_clk);
    check("idle_reached", 32'(ok), 32'd1);
    check("inhibit_len",  32'(inh_len_last), 32'(INH));
    check("start_on_last_inhibit", 32'(inh_data_cnt - k0), 32'd1);
    check("start_bit",    32'(start_bit), 32'd0);
    check("line_bits",    32'(bits), 32'(v.exp_bits));
    check("done_pulses",  32'(done_cnt - d0), 32'(v.exp_done));
    check("error_pulses", 32'(err_cnt - e0), 32'(v.exp_err));
    check("oe_released",  32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
  endtask

  initial begin
    int d0, e0, s0;
    bit ok;
    logic [9:0] bits;
    logic start_bit;

    // Hand-computed frames; parity = odd (~^data).
    vecs[0] = '{8'hED, 1'b1, 10'h3ED, 1, 0};  // 6 ones -> parity 1
    vecs[1] = '{8'hF4, 1'b1, 10'h2F4, 1, 0};  // 5 ones -> parity 0
    vecs[2] = '{8'hA5, 1'b0, 10'h3A5, 0, 1};  // no ack -> error
    vecs[3] = '{8'h00, 1'b1, 10'h300, 1, 0};  // 0 ones -> parity 1

    repeat (3) @(negedge in_clk);
    check("reset_clk_oe",  32'(ps2_clk_oe),  32'd0);
    check("reset_data_oe", 32'(ps2_data_oe), 32'd0);
    check("reset_busy",    32'(out_busy),    32'd0);
    check("reset_pulses",  32'({out_done, out_error}), 32'd0);
    in_reset = 1'b0;
    repeat (3) @(negedge in_clk);

    for (int v = 0; v < 4; v++) run_vector(vecs[v]);

    // Device never clocks: error exactly TMO cycles after RELEASE entry.
    d0 = done_cnt; e0 = err_cnt;
    request(8'hC3);
    wait_release(ok);
    check("tmo_release_seen", 32'(ok), 32'd1);
    for (int i = 0; i < 2 * TMO && err_cnt == e0; i++) @(negedge in_clk);
    repeat (3) @(negedge in_clk);
    check("tmo_error_pulses", 32'(err_cnt - e0), 32'd1);
    check("tmo_latency",      32'(err_cyc - rel_cyc), 32'(TMO));
    check("tmo_done_pulses",  32'(done_cnt - d0), 32'd0);
    check("tmo_oe_released",  32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    check("tmo_idle",         32'(out_busy), 32'd0);

    // in_valid with 0x00 during a 0xFF transfer must be ignored.
    d0 = done_cnt; s0 = inh_starts;
    request(8'hFF);
    fork
      serve(1'b1, 0, bits, start_bit);
      begin
        repeat (150) @(negedge in_clk);
        in_valid = 1'b1;
        in_data  = 8'h00;
        repeat (5) @(negedge in_clk);
        in_valid = 1'b0;
      end
    join
    wait_idle(ok);
    repeat (50) @(negedge in_clk);
    check("busy_req_bits",    32'(bits), 32'h3FF);
    check("busy_req_done",    32'(done_cnt - d0), 32'd1);
    check("busy_req_frames",  32'(inh_starts - s0), 32'd1);
    check("busy_req_idle",    32'(out_busy), 32'd0);

    // Reset at fall 5, then a clean 0xED transfer.
    d0 = done_cnt; e0 = err_cnt;
    request(8'hED);
    serve(1'b1, 5, bits, start_bit);
    repeat (10) @(negedge in_clk);
    check("rst_no_done",  32'(done_cnt - d0), 32'd0);
    check("rst_no_error", 32'(err_cnt - e0), 32'd0);
    run_vector(vecs[0]);

    check("never_both_pulses", 32'(both_cnt), 32'd0);
    check("busy_after_done",   32'(busy_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
